tty_dbg_tx: RTL and testbench

- Consumer end of the CPU debug tty stream: tty_stb, tty_dat[7:0], tty_end.
- Buffers strobed bytes in a small FIFO and serializes them 8N1, LSB first, onto a dedicated debug TX pin.
- Sits in the board top level beside the CPU wrapper and is clocked by the system positive clock.
- Reports overflow, busy and drained status for LEDs or a test bench.

---
 rtl/tty_dbg_tx.sv | 142 ++++++++++++++
 tb/tb_tty_dbg_tx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tty_dbg_tx.sv
// Debug tty byte sink: strobed bytes are queued in a small FIFO and sent 8N1, LSB first, on txd.
// Status outputs report dropped bytes, activity, and completion after an end request.
`timescale 1ns/1ps
module tty_dbg_tx #(
  parameter int unsigned CLK_HZ   = 54000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned FIFO_LOG = 4
) (
  input  logic       sys_clk_p,
  input  logic       sys_rst,
  input  logic       tty_stb,
  input  logic [7:0] tty_dat,
  input  logic       tty_end,
  output logic       txd,
  output logic       ovf,
  output logic       busy,
  output logic       done
);
  localparam int unsigned DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned DEPTH = 1 << FIFO_LOG;
  localparam int unsigned CW    = $clog2(DIV);
  localparam int unsigned CNTW  = FIFO_LOG + 1;
  localparam logic [CW-1:0]   CNT_TOP  = CW'(DIV - 1);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [2:0]          bit_idx, bit_n;
  logic [7:0]          sh, sh_n;
  logic                pop, push, full, txd_n, end_req;
  logic [7:0]          mem [DEPTH];
  logic [FIFO_LOG-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0]     count;

  assign full = (count == FULL_CNT);
  assign push = tty_stb & ~end_req & ~full;

  always_ff @(posedge sys_clk_p) begin
    if (sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      end_req <= 1'b0;
      txd     <= 1'b1;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      sh      <= sh_n;
      txd     <= txd_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // A full FIFO drops the byte even if a pop frees a slot on this edge.
      if (tty_stb & ~end_req & full) ovf <= 1'b1;
      if (tty_end) end_req <= 1'b1;
      busy <= (count != '0) || (state != IDLE);
      if (end_req && (count == '0) && (state == IDLE)) done <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_p) begin
    if (push) mem[wr_ptr] <= tty_dat;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = sh;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          sh_n    = mem[rd_ptr];
          cnt_n   = CNT_TOP;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          cnt_n   = CNT_TOP;
          state_n = DATA;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = CNT_TOP;
          sh_n  = sh >> 1;
          bit_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (count != '0) begin
            pop     = 1'b1;
            sh_n    = mem[rd_ptr];
            cnt_n   = CNT_TOP;
            bit_n   = '0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level is derived from the next state so txd itself is a plain register.
  always_comb begin
    txd_n = 1'b1;
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = sh_n[0];
      default: txd_n = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_tty_dbg_tx.sv
// Scoreboard bench for tty_dbg_tx: a frame-level model predicts accepted bytes, frame start
// cycles and status flags; a line monitor decodes txd and compares against the queue.
`timescale 1ns/1ps
module tb_tty_dbg_tx;
  localparam int unsigned CLK_HZ   = 1000;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned FIFO_LOG = 2;
  localparam int unsigned DIV      = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int unsigned DEPTH    = 1 << FIFO_LOG;
  localparam int          FRAME    = 10 * DIV;

  logic       clk = 1'b0, rst = 1'b0, tty_stb = 1'b0, tty_end = 1'b0;
  logic [7:0] tty_dat = 8'h00;
  logic       txd, ovf, busy, done;

  tty_dbg_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_LOG(FIFO_LOG)) dut (
    .sys_clk_p(clk), .sys_rst(rst), .tty_stb(tty_stb), .tty_dat(tty_dat),
    .tty_end(tty_end), .txd(txd), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes waiting, line occupancy, sticky flags.
  int         cyc = 0;
  logic [7:0] pend[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         m_active = 0, m_end = 0, m_ovf = 0, m_busy = 0, m_done = 0;
  bit         mon_abort = 0, chk_en = 0, pre_act, pre_end;
  int         m_until = 0, pre_n;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend.delete(); exp_q.delete(); start_q.delete();
      m_active = 0; m_end = 0; m_ovf = 0; m_busy = 0; m_done = 0; m_until = 0;
      mon_abort = 1; chk_en = 1;
    end else begin
      pre_n = pend.size(); pre_act = m_active; pre_end = m_end;
      m_busy = (pre_n != 0) || pre_act;
      if (pre_end && pre_n == 0 && !pre_act) m_done = 1;
      if (tty_end) m_end = 1;
      if (pre_n != 0 && (!pre_act || cyc == m_until)) begin
        void'(pend.pop_front());
        start_q.push_back(cyc);
        m_active = 1;
        m_until  = cyc + FRAME;
      end else if (pre_act && cyc == m_until) begin
        m_active = 0;
      end
      if (tty_stb && !pre_end) begin
        if (pre_n == int'(DEPTH)) m_ovf = 1;
        else begin
          pend.push_back(tty_dat);
          exp_q.push_back(tty_dat);
        end
      end
    end
  end

  // Line monitor: decodes each frame and checks it against the scoreboard.
  bit         mon_active = 0;
  int         mon_off, mon_start_exp, line_err, st_err = 0, frames = 0, k;
  logic [7:0] mon_exp, mon_got;
  logic       lvl;

  always @(negedge clk) begin
    if (chk_en && (ovf !== m_ovf || busy !== m_busy || done !== m_done)) st_err++;
    if (mon_abort) begin
      mon_abort  = 0;
      mon_active = 0;
    end else if (!mon_active && txd === 1'b0) begin
      frames++;
      mon_active = 1; mon_off = 0; line_err = 0; mon_got = 8'h00;
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_frame: got a start bit, expected an idle line at %0t", $time);
        mon_exp = 8'h00;
      end else begin
        mon_exp       = exp_q.pop_front();
        mon_start_exp = (start_q.size() != 0) ? start_q.pop_front() : -1;
        check("frame_start_cycle", cyc, mon_start_exp);
      end
    end
    if (mon_active) begin
      k   = mon_off / DIV;
      lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : mon_exp[k-1];
      if (txd !== lvl) line_err++;
      if (k >= 1 && k <= 8 && (mon_off % DIV) == DIV / 2) mon_got[k-1] = txd;
      if (mon_off == FRAME - 1) begin
        check("frame_data", mon_got, mon_exp);
        check("frame_shape_errs", line_err, 0);
        mon_active = 0;
      end else begin
        mon_off++;
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    tty_stb = 1'b1;
    tty_dat = d;
    @(negedge clk);
    tty_stb = 1'b0;
  endtask

  task automatic pulse_end();
    tty_end = 1'b1;
    @(negedge clk);
    tty_end = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || mon_active || pend.size() != 0 || m_active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained_in_budget"}, int'(n < budget), 1);
    check({name, "_scoreboard_empty"}, exp_q.size(), 0);
    check({name, "_status_trace_errs"}, st_err, 0);
    st_err = 0;
  endtask

  initial begin
    int f0;
    @(negedge clk);

    // 1: reset values and a single A5 frame
    do_reset(2);
    check("p1_reset_txd", txd, 1);
    check("p1_reset_ovf", ovf, 0);
    check("p1_reset_busy", busy, 0);
    check("p1_reset_done", done, 0);
    send(8'hA5);
    wait_idle("p1", 400);

    // 2: back-to-back frames
    do_reset(2);
    send(8'h00);
    send(8'hFF);
    wait_idle("p2", 600);
    check("p2_ovf", ovf, 0);

    // 3: overflow on a depth-4 FIFO
    do_reset(2);
    f0 = frames;
    for (int i = 1; i <= 6; i++) send(8'(i));
    wait_idle("p3", 1200);
    check("p3_ovf", ovf, 1);
    check("p3_frames", frames - f0, 5);

    // 4: end request with bytes queued, later strobe ignored
    do_reset(2);
    f0 = frames;
    send(8'h11); send(8'h22); send(8'h33);
    pulse_end();
    send(8'h55);
    wait_idle("p4", 800);
    check("p4_ovf", ovf, 0);
    check("p4_done", done, 1);
    check("p4_busy", busy, 0);
    check("p4_frames", frames - f0, 3);

    // 5: reset in the middle of a frame's data bits
    do_reset(2);
    f0 = frames;
    send(8'hC3); send(8'h3C); send(8'h81);
    repeat (35) @(negedge clk);
    do_reset(1);
    check("p5_txd_after_reset", txd, 1);
    check("p5_busy_after_reset", busy, 0);
    repeat (300) @(negedge clk);
    check("p5_frames", frames - f0, 1);
    check("p5_busy_later", busy, 0);
    check("p5_status_trace_errs", st_err, 0);
    st_err = 0;

    // 6: end on an idle line
    do_reset(2);
    f0 = frames;
    pulse_end();
    check("p6_done_after_1_edge", done, 0);
    @(negedge clk);
    check("p6_done_after_2_edges", done, 1);
    send(8'h77);
    repeat (50) @(negedge clk);
    check("p6_frames", frames - f0, 0);
    check("p6_txd_idle", txd, 1);
    wait_idle("p6", 50);

    // 7: randomized traffic at three densities, then an end request
    do_reset(2);
    for (int blk = 0; blk < 3; blk++) begin
      for (int c = 0; c < 200; c++) begin
        tty_stb = ($urandom_range(0, 99) < ((blk == 1) ? 60 : (blk == 0) ? 5 : 15));
        tty_dat = 8'($urandom);
        @(negedge clk);
      end
    end
    tty_stb = 1'b0;
    pulse_end();
    for (int c = 0; c < 5; c++) send(8'($urandom));
    wait_idle("p7", 2000);
    check("p7_done", done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
